// File: rtl/hazard_scoreboard.sv
// ID-stage countdown scoreboard: RAW/WAW stall, branch/jump flush and a
// saturating stall-cycle counter for multi-cycle producers.
module hazard_scoreboard #(
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int LAT_WIDTH       = 3,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            idValid,
  input  logic [RF_ADDR_WIDTH-1:0]        idRs1,
  input  logic [RF_ADDR_WIDTH-1:0]        idRs2,
  input  logic                            idRs1Used,
  input  logic                            idRs2Used,
  input  logic [RF_ADDR_WIDTH-1:0]        idRd,
  input  logic                            idRdWrite,
  input  logic [LAT_WIDTH-1:0]            idLat,
  input  logic                            idIsStore,
  input  logic                            branchOrJump,
  output logic                            stall,
  output logic                            flush,
  output logic [(2**RF_ADDR_WIDTH)-1:0]   busyMask,
  output logic [STALL_CNT_WIDTH-1:0]      stallCycles
);

  localparam int NREGS = 2**RF_ADDR_WIDTH;
  localparam logic [LAT_WIDTH-1:0] LAT_ZERO = '0;
  localparam logic [LAT_WIDTH-1:0] LAT_ONE  = LAT_WIDTH'(1);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1);

  // x0 has no storage; it is read as a constant zero through cntView_s
  logic [LAT_WIDTH-1:0]       cnt_r [1:NREGS-1];
  logic [LAT_WIDTH-1:0]       cntView_s [NREGS];
  logic [STALL_CNT_WIDTH-1:0] stallCycles_r;
  logic [LAT_WIDTH-1:0]       storeSlack_s;
  logic                       raw1_s;
  logic                       raw2_s;
  logic                       waw_s;
  logic                       stall_s;
  logic                       issue_s;

  // Full-width view of the scoreboard with x0 tied to zero
  always_comb begin
    cntView_s[0] = LAT_ZERO;
    for (int r = 1; r < NREGS; r++) begin
      cntView_s[r] = cnt_r[r];
    end
  end

  // Hazard detection, stall/issue decision and busy mask
  always_comb begin
    busyMask     = '0;
    storeSlack_s = idIsStore ? LAT_ONE : LAT_ZERO;
    raw1_s  = idRs1Used && (idRs1 != '0) && (cntView_s[idRs1] != LAT_ZERO);
    raw2_s  = idRs2Used && (idRs2 != '0) && (cntView_s[idRs2] > storeSlack_s);
    waw_s   = idRdWrite && (idRd != '0) && (cntView_s[idRd] > idLat);
    stall_s = idValid && !branchOrJump && (raw1_s || raw2_s || waw_s);
    issue_s = idValid && !stall_s && !branchOrJump;
    for (int r = 0; r < NREGS; r++) begin
      busyMask[r] = (cntView_s[r] != LAT_ZERO);
    end
  end

  assign stall       = stall_s;
  assign flush       = branchOrJump;
  assign stallCycles = stallCycles_r;

  // Per-register countdown; a new issue overrides the decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) begin
        cnt_r[r] <= LAT_ZERO;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (issue_s && idRdWrite && (idRd == RF_ADDR_WIDTH'(r)) && (idLat != LAT_ZERO)) begin
          cnt_r[r] <= idLat;
        end else if (cnt_r[r] != LAT_ZERO) begin
          cnt_r[r] <= cnt_r[r] - LAT_ONE;
        end else begin
          cnt_r[r] <= LAT_ZERO;
        end
      end
    end
  end

  // Saturating stall-cycle performance counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles_r <= '0;
    end else if (stall_s && (stallCycles_r != '1)) begin
      stallCycles_r <= stallCycles_r + STALL_ONE;
    end else begin
      stallCycles_r <= stallCycles_r;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a model that tracks the absolute cycle each register becomes free.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int LW = 3;
  localparam int SW = 32;
  localparam int NR = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          idValid, idRs1Used, idRs2Used, idRdWrite, idIsStore, branchOrJump;
  logic [AW-1:0] idRs1, idRs2, idRd;
  logic [LW-1:0] idLat;
  logic          stall, flush;
  logic [NR-1:0] busyMask;
  logic [SW-1:0] stallCycles;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint readyAt [NR];
  longint stallCount = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.RF_ADDR_WIDTH(AW), .LAT_WIDTH(LW), .STALL_CNT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
    .idRs1Used(idRs1Used), .idRs2Used(idRs2Used), .idRd(idRd), .idRdWrite(idRdWrite),
    .idLat(idLat), .idIsStore(idIsStore), .branchOrJump(branchOrJump),
    .stall(stall), .flush(flush), .busyMask(busyMask), .stallCycles(stallCycles)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Cycles still outstanding before register r can be consumed
  function automatic longint remaining(input int r);
    if (r == 0) return 0;
    return (readyAt[r] > cyc) ? readyAt[r] - cyc : 0;
  endfunction

  function automatic bit modelStall();
    bit r1, r2, w;
    r1 = idRs1Used && remaining(int'(idRs1)) > 0;
    r2 = idRs2Used && remaining(int'(idRs2)) > (idIsStore ? 1 : 0);
    w  = idRdWrite && remaining(int'(idRd)) > longint'(idLat);
    return idValid && !branchOrJump && (r1 || r2 || w);
  endfunction

  function automatic logic [NR-1:0] modelBusy();
    logic [NR-1:0] m;
    m = '0;
    for (int r = 1; r < NR; r++) m[r] = remaining(r) > 0;
    return m;
  endfunction

  task automatic setIn(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rdw, input int lat, input bit st, input bit bj);
    idValid = v; idRs1 = AW'(rs1); idRs1Used = u1; idRs2 = AW'(rs2); idRs2Used = u2;
    idRd = AW'(rd); idRdWrite = rdw; idLat = LW'(lat); idIsStore = st; branchOrJump = bj;
    #1;
  endtask

  task automatic setIdle();
    setIn(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Called just after inputs settle in the low phase; checks, clocks, updates model
  task automatic step();
    bit es;
    es = modelStall();
    checkVal("stall", 64'(stall), 64'(es));
    checkVal("flush", 64'(flush), 64'(branchOrJump));
    checkVal("busyMask", 64'(busyMask), 64'(modelBusy()));
    checkVal("stallCycles", 64'(stallCycles), 64'(stallCount));
    @(posedge clk);
    if (idValid && !es && !branchOrJump && idRdWrite && idRd != '0 && idLat != '0)
      readyAt[idRd] = cyc + 1 + longint'(idLat);
    if (es && stallCount < 64'hFFFF_FFFF) stallCount++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkVal("rst_stall", 64'(stall), 64'd0);
    checkVal("rst_busy", 64'(busyMask), 64'd0);
    checkVal("rst_cycles", 64'(stallCycles), 64'd0);
    for (int r = 0; r < NR; r++) readyAt[r] = 0;
    stallCount = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NR; r++) readyAt[r] = 0;
    rst_n = 1'b0;
    setIn(1'b1, 3, 1'b1, 4, 1'b1, 5, 1'b1, 2, 1'b0, 1'b0);
    checkVal("init_stall", 64'(stall), 64'd0);
    checkVal("init_busy", 64'(busyMask), 64'd0);
    checkVal("init_cycles", 64'(stallCycles), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: exactly one stall cycle
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1, 1'b0, 1'b0); step();
    setIn(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b1, 0, 1'b0, 1'b0);
    checkVal("lu_stall", 64'(stall), 64'd1); step();
    checkVal("lu_release", 64'(stall), 64'd0); step();
    setIdle();
    checkVal("lu_count", 64'(stallCycles), 64'd1); step();

    // Load then store data operand: no stall; as address operand: stall
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1, 1'b0, 1'b0); step();
    setIn(1'b1, 1, 1'b1, 7, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
    checkVal("st_data", 64'(stall), 64'd0); step();
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1, 1'b0, 1'b0); step();
    setIn(1'b1, 7, 1'b1, 2, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
    checkVal("st_addr", 64'(stall), 64'd1); step(); step();

    // Latency-4 producer: four stall cycles
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 4, 1'b0, 1'b0); step();
    setIn(1'b1, 3, 1'b1, 0, 1'b0, 8, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkVal("mc_stall", 64'(stall), 64'd1);
      checkVal("mc_busy3", 64'(busyMask[3]), 64'd1);
      step();
    end
    checkVal("mc_release", 64'(stall), 64'd0);
    checkVal("mc_busy3_clr", 64'(busyMask[3]), 64'd0); step();
    setIdle();
    checkVal("mc_count", 64'(stallCycles), 64'd4); step();

    // WAW: lat-1 writer waits until older lat-4 writer is within one cycle
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 4, 1'b0, 1'b0); step();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkVal("waw_stall", 64'(stall), 64'd1); step();
    end
    checkVal("waw_issue", 64'(stall), 64'd0); step();
    setIdle();
    checkVal("waw_busy9", 64'(busyMask[9]), 64'd1); step();
    checkVal("waw_busy9_clr", 64'(busyMask[9]), 64'd0); step();

    // Flush beats stall and suppresses issue
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 2, 1'b0, 1'b0); step();
    setIn(1'b1, 4, 1'b1, 0, 1'b0, 10, 1'b1, 3, 1'b0, 1'b1);
    checkVal("fl_flush", 64'(flush), 64'd1);
    checkVal("fl_stall", 64'(stall), 64'd0); step();
    setIdle();
    checkVal("fl_busy", 64'(busyMask), 64'h10); step();

    // x0 destination is never tracked; x0 source never stalls
    doReset();
    setIn(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 4, 1'b0, 1'b0); step();
    setIn(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    checkVal("x0_busy", 64'(busyMask), 64'd0);
    checkVal("x0_stall", 64'(stall), 64'd0); step();

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      setIn($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
